// File: rtl/audio_pacer_if.sv
// audio_pacer_if: sample input strobe, stereo output strobe and FIFO status of the audio pacer.
interface audio_pacer_if #(
  parameter int IN_WIDTH = 10,
  parameter int DEPTH_LOG2 = 4
);
  logic signed [IN_WIDTH-1:0] in_data;
  logic in_valid;
  logic signed [IN_WIDTH-1:0] out_left;
  logic signed [IN_WIDTH-1:0] out_right;
  logic out_valid;
  logic [DEPTH_LOG2:0] level;
  logic running;
  logic overflow;
  logic underflow;
  modport master (
    output in_data, in_valid,
    input out_left, out_right, out_valid, level, running, overflow, underflow
  );
  modport slave (
    input in_data, in_valid,
    output out_left, out_right, out_valid, level, running, overflow, underflow
  );
endinterface

// File: rtl/audio_pacer.sv
// audio_pacer: buffers bursty mono samples in a FIFO and replays them on both channels at a fixed tick rate.
module audio_pacer #(
  parameter int IN_WIDTH = 10,
  parameter int DEPTH_LOG2 = 4,
  parameter int PERIOD = 1536
) (
  input logic clk,
  input logic reset_n,
  audio_pacer_if.slave bus
);
  localparam int CW = $clog2(PERIOD);
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(2 ** DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] HALF = (DEPTH_LOG2 + 1)'(2 ** (DEPTH_LOG2 - 1));
  typedef enum logic {PRIME, RUN} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [DEPTH_LOG2:0] level;
  logic signed [IN_WIDTH-1:0] mem [2 ** DEPTH_LOG2];
  logic signed [IN_WIDTH-1:0] sample;
  logic tick, empty, full, rd, wr;
  assign tick = cnt == LAST;
  assign empty = level == '0;
  assign full = level == FULL;
  assign bus.level = level;
  assign bus.running = state == RUN;
  always_comb begin
    state_nx = state;
    rd = 1'b0;
    wr = 1'b0;
    sample = '0;
    rd = tick && (state == RUN ? !empty : level >= HALF);
    state_nx = !tick ? state : (state == RUN ? (empty ? PRIME : RUN) : (level >= HALF ? RUN : PRIME));
    wr = bus.in_valid && (!full || rd);
    sample = rd ? mem[rptr] : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)
      state <= PRIME;
    else
      state <= state_nx;
  // A full FIFO still accepts a write on a read tick: the head is consumed before the slot is reused.
  always_ff @(posedge clk)
    if (wr)
      mem[wptr] <= bus.in_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      wptr <= '0;
      rptr <= '0;
      level <= '0;
      bus.out_left <= '0;
      bus.out_right <= '0;
      bus.out_valid <= 1'b0;
      bus.overflow <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      wptr <= wr ? wptr + 1'b1 : wptr;
      rptr <= rd ? rptr + 1'b1 : rptr;
      level <= level + (DEPTH_LOG2 + 1)'(wr) - (DEPTH_LOG2 + 1)'(rd);
      bus.out_left <= tick ? sample : bus.out_left;
      bus.out_right <= tick ? sample : bus.out_right;
      bus.out_valid <= tick;
      bus.overflow <= bus.in_valid && full && !rd;
      bus.underflow <= tick && state == RUN && empty;
    end
endmodule

// File: doc/audio_pacer.md
AUDIO_PACER -- requirements
Module: audio_pacer

Interface
REQ-001 Parameter: IN_WIDTH, default 10, sample width of the mono audio in and of both outputs.
REQ-002 Parameter: DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 entries.
REQ-003 Parameter: PERIOD, default 1536, clocks per output sample (73.728 MHz / 1536 = 48 kHz).
REQ-004 Port: clk  input  1  system clock, 73.728 MHz; all logic on rising edge.
REQ-005 Port: reset_n  input  1  asynchronous active-low reset.
REQ-006 Port: in_data  input  signed IN_WIDTH  demodulated mono audio sample.
REQ-007 Port: in_valid  input  1  one-cycle strobe; in_data is valid this cycle.
REQ-008 Port: out_left  output  signed IN_WIDTH  left sample to the I2S transmitter.
REQ-009 Port: out_right  output  signed IN_WIDTH  right sample; always equal to out_left.
REQ-010 Port: out_valid  output  1  one-cycle strobe, exactly once per PERIOD clocks.
REQ-011 Port: level  output  DEPTH_LOG2+1  current FIFO occupancy, 0..2**DEPTH_LOG2.
REQ-012 Port: running  output  1  high in RUN state, low in PRIME state.
REQ-013 Port: overflow  output  1  one-cycle pulse when an input sample is dropped.
REQ-014 Port: underflow  output  1  one-cycle pulse when a tick finds the FIFO empty in RUN.

Function
REQ-015 Period counter counts 0..PERIOD-1 and wraps; a tick occurs in the cycle it equals PERIOD-1.
REQ-016 Tick cadence is fixed: counter is never reloaded by in_valid, level or state.
REQ-017 out_valid, out_left, out_right are registered; on a tick they update on the same clock edge, so out_valid is high for exactly the one cycle after the tick edge.
REQ-018 Write: in_valid with level < depth stores in_data at the write pointer and advances it.
REQ-019 Write when full: in_valid with level == depth and no read in the same cycle drops the sample and pulses overflow the next cycle; FIFO contents are unchanged.
REQ-020 Write when full with a simultaneous read is accepted; level stays at depth; no overflow.
REQ-021 Pointers are DEPTH_LOG2 bits and wrap modulo depth.
REQ-022 Simultaneous accepted write and read leave level unchanged.
REQ-023 State PRIME: on a tick, output samples are 0; no FIFO read occurs.
REQ-024 PRIME -> RUN at a tick when level >= depth/2; that same tick reads and outputs the FIFO head.
REQ-025 State RUN: on a tick with level > 0, the FIFO head is read and driven on both outputs.
REQ-026 RUN with level == 0 at a tick: outputs 0, underflow pulses with out_valid, state -> PRIME.
REQ-027 A write and an underflow in the same cycle: the write is accepted, level becomes 1, state still -> PRIME.
REQ-028 Samples pass through unmodified: no scaling, no sign change, in arrival order.
REQ-029 running reflects the registered state and changes on the clock edge after the deciding tick.

Reset
REQ-030 While reset_n is low: period counter 0, pointers 0, level 0, state PRIME.
REQ-031 While reset_n is low: out_left, out_right 0; out_valid, overflow, underflow, running 0.
REQ-032 FIFO storage need not be cleared; its contents are unreachable when level is 0.
REQ-033 Reset asserted mid-operation discards all buffered samples; the first tick after release comes PERIOD clocks after the first clock edge with reset_n high.

Verification
REQ-034 Release reset, no input for 3*PERIOD -> out_valid at cycles PERIOD, 2*PERIOD, 3*PERIOD with outputs 0; running 0; level 0.
REQ-035 Write 8 samples (1..8) before the first tick, then one sample per PERIOD -> running rises after the first tick; outputs 1,2,3,... on successive ticks; out_left == out_right.
REQ-036 Write 17 samples back-to-back with depth 16 and no tick -> level 16; one overflow pulse; the 17th sample is never output.
REQ-037 In RUN, stop input until the FIFO drains -> the first empty tick gives output 0 and one underflow pulse; running falls; later ticks output 0 until level reaches 8.
REQ-038 Full FIFO with in_valid on the tick cycle -> write accepted, level stays 16, no overflow; head sample output.
REQ-039 Assert reset_n low for 5 cycles mid-run with level 10 -> all outputs 0; level 0; PRIME; next tick PERIOD clocks after release.
